// File: rtl/spart_driver_fifo.sv
// SPART driver: programs the baud divisor, then echoes received bytes back
// through a small FIFO, optionally folding lowercase ASCII to uppercase.
module spart_driver_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD0      = 4800,
  parameter int BAUD1      = 9600,
  parameter int BAUD2      = 19200,
  parameter int BAUD3      = 38400,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [1:0]                    i_br_cfg,
  input  logic                          i_mode,
  input  logic                          i_rda,
  input  logic                          i_tbr,
  output logic                          o_iocs,
  output logic                          o_iorw,
  output logic [1:0]                    o_ioaddr,
  inout  logic [7:0]                    io_databus,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [15:0] DIV0 = 16'((CLK_HZ / BAUD0) - 1);
  localparam logic [15:0] DIV1 = 16'((CLK_HZ / BAUD1) - 1);
  localparam logic [15:0] DIV2 = 16'((CLK_HZ / BAUD2) - 1);
  localparam logic [15:0] DIV3 = 16'((CLK_HZ / BAUD3) - 1);

  typedef enum logic [2:0] {
    LOW_BAUD,
    HI_BAUD,
    IDLE,
    RX,
    TX
  } state_t;

  state_t          state;
  logic [1:0]      br_prev;
  logic [1:0]      br_sel;
  logic            reprog_pending;
  logic            baud_changed;
  logic [15:0]     divisor;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            fifo_empty;
  logic            fifo_full;

  logic [7:0]      head;
  logic [7:0]      tx_byte;
  logic [7:0]      bus_out;

  assign baud_changed = (i_br_cfg != br_prev);
  assign fifo_empty   = (o_fifo_count == '0);
  assign fifo_full    = (o_fifo_count == CW'(FIFO_DEPTH));

  always_comb begin
    divisor = DIV0;
    case (br_sel)
      2'b00:   divisor = DIV0;
      2'b01:   divisor = DIV1;
      2'b10:   divisor = DIV2;
      default: divisor = DIV3;
    endcase
  end

  // br_prev only sees a change for one cycle, so a change arriving during
  // RX/TX/programming is remembered in reprog_pending until IDLE services it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= LOW_BAUD;
      br_prev        <= i_br_cfg;
      br_sel         <= i_br_cfg;
      reprog_pending <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_fifo_count   <= '0;
      o_overflow     <= 1'b0;
    end else begin
      br_prev        <= i_br_cfg;
      reprog_pending <= (state == IDLE) ? 1'b0 : (reprog_pending | baud_changed);
      case (state)
        LOW_BAUD: state <= HI_BAUD;
        HI_BAUD:  state <= IDLE;
        IDLE: begin
          if (baud_changed || reprog_pending) begin
            state  <= LOW_BAUD;
            br_sel <= i_br_cfg;
          end else if (i_rda) begin
            state <= RX;
          end else if (i_tbr && !fifo_empty) begin
            state <= TX;
          end
        end
        RX: begin
          state <= IDLE;
          if (fifo_full) begin
            o_overflow <= 1'b1;
          end else begin
            wr_ptr       <= wr_ptr + 1'b1;
            o_fifo_count <= o_fifo_count + 1'b1;
          end
        end
        TX: begin
          state        <= IDLE;
          rd_ptr       <= rd_ptr + 1'b1;
          o_fifo_count <= o_fifo_count - 1'b1;
        end
        default: state <= LOW_BAUD;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && state == RX && !fifo_full) begin
      mem[wr_ptr] <= io_databus;
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    tx_byte = head;
    if (i_mode && head >= 8'h61 && head <= 8'h7A) begin
      tx_byte = head - 8'h20;
    end
  end

  always_comb begin
    o_iocs   = 1'b0;
    o_iorw   = 1'b0;
    o_ioaddr = 2'b00;
    bus_out  = '0;
    case (state)
      LOW_BAUD: begin
        o_iocs   = 1'b1;
        o_ioaddr = 2'b10;
        bus_out  = divisor[7:0];
      end
      HI_BAUD: begin
        o_iocs   = 1'b1;
        o_ioaddr = 2'b11;
        bus_out  = divisor[15:8];
      end
      RX: begin
        o_iocs = 1'b1;
        o_iorw = 1'b1;
      end
      TX: begin
        o_iocs  = 1'b1;
        bus_out = tx_byte;
      end
      default: ;
    endcase
  end

  assign io_databus = (o_iocs && !o_iorw) ? bus_out : 'z;

endmodule

// File: doc/spart_driver_fifo.md
SPART_DRIVER_FIFO -- requirements
Module: spart_driver_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameters BAUD0/BAUD1/BAUD2/BAUD3, defaults 4800/9600/19200/38400, rates selected by i_br_cfg 00/01/10/11.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two and at least 2; entries are 8 bits wide.
REQ-004 SHALL have port i_clk, input, 1 bit, single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port i_br_cfg, input, 2 bits, baud rate select.
REQ-007 SHALL have port i_mode, input, 1 bit, TX transform: 0 = raw echo, 1 = ASCII uppercase.
REQ-008 SHALL have port i_rda, input, 1 bit, SPART receive data available.
REQ-009 SHALL have port i_tbr, input, 1 bit, SPART transmit buffer ready.
REQ-010 SHALL have port o_iocs, output, 1 bit, SPART chip select.
REQ-011 SHALL have port o_iorw, output, 1 bit, 1 = read from SPART, 0 = write.
REQ-012 SHALL have port o_ioaddr, output, 2 bits: 00 = data, 10 = divisor low byte, 11 = divisor high byte.
REQ-013 SHALL have port io_databus, inout, 8 bits, shared SPART data bus.
REQ-014 SHALL have port o_fifo_count, output, $clog2(FIFO_DEPTH)+1 bits, current FIFO occupancy.
REQ-015 SHALL have port o_overflow, output, 1 bit, sticky flag set when a byte is received while the FIFO is full.

Function
REQ-016 SHALL compute each 16-bit divisor at elaboration as (CLK_HZ / BAUDn) - 1 using integer division; the defaults give 10415/5207/2603/1301.
REQ-017 SHALL register i_br_cfg every cycle into br_prev; baud_changed = (i_br_cfg != br_prev).
REQ-018 SHALL implement the states LOW_BAUD, HI_BAUD, IDLE, RX and TX.
REQ-019 SHALL make LOW_BAUD go to HI_BAUD, HI_BAUD go to IDLE, RX go to IDLE and TX go to IDLE, each unconditionally after one cycle.
REQ-020 SHALL resolve IDLE with priority baud_changed -> LOW_BAUD, then i_rda -> RX, then (i_tbr and FIFO not empty) -> TX, else stay in IDLE.
REQ-021 SHALL service a baud change only from IDLE; an RX or TX in progress always completes first.
REQ-022 SHALL decode outputs from the current state only; a change on i_br_cfg alone SHALL NOT alter the outputs within the same cycle.
REQ-023 SHALL drive LOW_BAUD as iocs=1, iorw=0, ioaddr=10, bus = divisor[7:0].
REQ-024 SHALL drive HI_BAUD as iocs=1, iorw=0, ioaddr=11, bus = divisor[15:8].
REQ-025 SHALL drive RX as iocs=1, iorw=1, ioaddr=00, bus = high-Z.
REQ-026 SHALL drive TX as iocs=1, iorw=0, ioaddr=00, bus = transformed FIFO head.
REQ-027 SHALL drive IDLE as iocs=0, iorw=0, ioaddr=00, bus = high-Z.
REQ-028 SHALL drive io_databus only when o_iocs=1 and o_iorw=0, and leave it high-Z otherwise.
REQ-029 SHALL, on the clock edge ending RX, push io_databus into the FIFO if it is not full; if it is full, the byte SHALL be discarded and o_overflow set.
REQ-030 SHALL, on the clock edge ending TX, pop the FIFO head.
REQ-031 SHALL have a minimum RX-to-bus latency of 2 cycles: RX in cycle N, IDLE in N+1, TX in N+2.
REQ-032 SHALL apply the uppercase transform when i_mode=1, sampled in the TX cycle: bytes 0x61..0x7A are output minus 0x20 and all others are unchanged; FIFO contents are never modified.
REQ-033 SHALL implement the FIFO with wrap-around read/write pointers of $clog2(FIFO_DEPTH) bits; o_fifo_count spans 0..FIFO_DEPTH.
REQ-034 SHALL never push and pop in the same cycle, since RX and TX are exclusive states.
REQ-035 SHALL preserve FIFO contents and o_overflow across a baud reprogram.
REQ-036 SHALL make o_overflow sticky; it is cleared only by i_rst.

Reset
REQ-037 SHALL, while i_rst=1 at a clock edge, set state=LOW_BAUD, empty the FIFO (pointers and count 0), clear o_overflow and load br_prev<=i_br_cfg.
REQ-038 SHALL, once i_rst deasserts, program the divisor in two cycles before any data transfer.
REQ-039 SHALL abort any RX or TX in progress when i_rst asserts, with no push or pop occurring in that cycle.

Verification
REQ-040 SHALL test: reset with br_cfg=11 -> cycle 1 addr 10 bus 0x15, cycle 2 addr 11 bus 0x05, then IDLE with iocs=0.
REQ-041 SHALL test: rda pulse with bus 0x41 and tbr=1 -> RX, IDLE, TX with bus 0x41; count goes 1 then 0.
REQ-042 SHALL test: i_mode=1, receive 0x7A, 0x5B, 0x61 -> TX bytes 0x5A, 0x5B, 0x41 in order.
REQ-043 SHALL test: tbr=0 and 9 received bytes with depth 8 -> count=8, o_overflow=1, 9th byte dropped, first 8 transmitted in order once tbr=1.
REQ-044 SHALL test: br_cfg changes 00->01 during RX -> RX completes, then addr 10 bus 0x57, addr 11 bus 0x14, FIFO unchanged.
REQ-045 SHALL test: rda and tbr both high in IDLE with FIFO non-empty -> RX chosen first; i_rst during TX -> FIFO empty, next state LOW_BAUD.
